// File: rtl/edge_sobel_3x3_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : edge_sobel_3x3_if                                            |
// | Description : Matrix-in / result-out handshake bundle for the Sobel stage. |
// |               Signal names are from the filter's point of view.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface edge_sobel_3x3_if #(
  parameter int P_PIXEL_DEPTH = 8
);
  logic [8*P_PIXEL_DEPTH-1:0] i_pixel_matrix;
  logic [P_PIXEL_DEPTH-1:0]   i_threshold;
  logic                       i_valid;
  logic                       o_ready;
  logic                       i_ready;
  logic                       o_valid;
  logic [P_PIXEL_DEPTH-1:0]   o_magnitude;
  logic                       o_edge;

  // Filter side: consumes matrices, produces results.
  modport slave (
    input  i_pixel_matrix,
    input  i_threshold,
    input  i_valid,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_magnitude,
    output o_edge
  );

  // Environment side: supplies matrices, collects results.
  modport master (
    output i_pixel_matrix,
    output i_threshold,
    output i_valid,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_magnitude,
    input  o_edge
  );
endinterface
`default_nettype wire

// File: rtl/edge_sobel_3x3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : edge_sobel_3x3                                               |
// | Description : 3-stage pipelined Sobel gradient magnitude with threshold.   |
// |               S1 captures the 8-neighbour matrix, S2 holds Gx/Gy, S3 holds |
// |               the saturated |Gx|+|Gy| and the edge flag.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module edge_sobel_3x3 #(
  parameter int P_PIXEL_DEPTH = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  edge_sobel_3x3_if.slave   bus
);

  // Gradients span +/-4*(2^N-1), which needs N+3 signed bits.
  localparam int c_grad_w = P_PIXEL_DEPTH + 3;
  localparam logic [P_PIXEL_DEPTH-1:0] c_pix_max = '1;

  logic                       r_s1_valid;
  logic [8*P_PIXEL_DEPTH-1:0] r_s1_matrix;
  logic [P_PIXEL_DEPTH-1:0]   r_s1_threshold;

  logic                       r_s2_valid;
  logic signed [c_grad_w-1:0] r_s2_gx;
  logic signed [c_grad_w-1:0] r_s2_gy;
  logic [P_PIXEL_DEPTH-1:0]   r_s2_threshold;

  logic                       r_s3_valid;
  logic [P_PIXEL_DEPTH-1:0]   r_s3_magnitude;
  logic                       r_s3_edge;

  logic                       w_advance;
  logic [c_grad_w-1:0]        w_px [8];
  logic signed [c_grad_w-1:0] w_gx;
  logic signed [c_grad_w-1:0] w_gy;
  logic [c_grad_w-1:0]        w_abs_gx;
  logic [c_grad_w-1:0]        w_abs_gy;
  logic [c_grad_w-1:0]        w_raw;
  logic [P_PIXEL_DEPTH-1:0]   w_sat;
  logic                       w_edge;

  // The whole pipe moves as one: it advances unless a result is waiting
  // on a downstream that is not ready.
  assign w_advance   = !r_s3_valid || bus.i_ready;
  assign bus.o_ready = w_advance;
  assign bus.o_valid = r_s3_valid;
  assign bus.o_magnitude = r_s3_magnitude;
  assign bus.o_edge  = r_s3_edge;

  // Split the packed matrix, zero-extended to gradient width.
  // Index: 0 tl, 1 t, 2 tr, 3 ml, 4 mr, 5 bl, 6 b, 7 br.
  generate
    for (genvar k = 0; k < 8; k++) begin : g_unpack
      assign w_px[k] = {3'b000, r_s1_matrix[(7-k)*P_PIXEL_DEPTH +: P_PIXEL_DEPTH]};
    end
  endgenerate

  // Sobel kernels; the two's-complement wrap of the subtraction is exact
  // because the true result always fits in c_grad_w signed bits.
  assign w_gx = (w_px[2] + (w_px[4] << 1) + w_px[7])
              - (w_px[0] + (w_px[3] << 1) + w_px[5]);
  assign w_gy = (w_px[5] + (w_px[6] << 1) + w_px[7])
              - (w_px[0] + (w_px[1] << 1) + w_px[2]);

  // L1 magnitude, clamped to the pixel range, then thresholded.
  assign w_abs_gx = r_s2_gx[c_grad_w-1] ? -r_s2_gx : r_s2_gx;
  assign w_abs_gy = r_s2_gy[c_grad_w-1] ? -r_s2_gy : r_s2_gy;
  assign w_raw    = w_abs_gx + w_abs_gy;
  assign w_sat    = (w_raw[c_grad_w-1:P_PIXEL_DEPTH] != '0) ? c_pix_max
                                                            : w_raw[P_PIXEL_DEPTH-1:0];
  assign w_edge   = (w_sat >= r_s2_threshold);

  // S1: capture matrix and threshold; bubbles leave the data untouched.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_s1_valid     <= 1'b0;
      r_s1_matrix    <= '0;
      r_s1_threshold <= '0;
    end else if (w_advance) begin
      r_s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        r_s1_matrix    <= bus.i_pixel_matrix;
        r_s1_threshold <= bus.i_threshold;
      end
    end
  end

  // S2: register the signed gradients alongside their threshold.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_s2_valid     <= 1'b0;
      r_s2_gx        <= '0;
      r_s2_gy        <= '0;
      r_s2_threshold <= '0;
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_gx        <= w_gx;
        r_s2_gy        <= w_gy;
        r_s2_threshold <= r_s1_threshold;
      end
    end
  end

  // S3: output register; holds the last result through bubbles and stalls.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_s3_valid     <= 1'b0;
      r_s3_magnitude <= '0;
      r_s3_edge      <= 1'b0;
    end else if (w_advance) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_magnitude <= w_sat;
        r_s3_edge      <= w_edge;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_edge_sobel_3x3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_edge_sobel_3x3                                            |
// | Description : Directed self-checking bench for edge_sobel_3x3.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_edge_sobel_3x3;

  localparam int P = 8;

  typedef struct {
    logic [63:0] m;
    logic [7:0]  thr;
    logic [7:0]  mag;
    logic        edg;
  } vec_t;

  typedef struct packed {
    logic [7:0] mag;
    logic       edg;
  } res_t;

  logic clk;
  logic rst_n;

  int   n_checks;
  int   n_fails;
  int   delivered;
  int   cur_idx;
  logic accepted;
  logic s_valid, s_ready, s_edge;
  logic [7:0] s_mag;
  logic held_valid, held_edge;
  logic [7:0] held_mag;

  vec_t vecs [8];
  res_t exp_q [$];
  int   stream_idx [5];

  edge_sobel_3x3_if #(.P_PIXEL_DEPTH(P)) bus ();

  edge_sobel_3x3 #(.P_PIXEL_DEPTH(P)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mat(input logic [7:0] tl, t, tr, ml, mr, bl, b, br);
    return {tl, t, tr, ml, mr, bl, b, br};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int idx);
    cur_idx            = idx;
    bus.i_valid        = 1'b1;
    bus.i_pixel_matrix = vecs[idx].m;
    bus.i_threshold    = vecs[idx].thr;
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
  endtask

  // One clock: sample at the falling edge, score any delivered result,
  // note whether a matrix is about to be accepted, then step past the rising edge.
  task automatic cycle();
    res_t r;
    @(negedge clk);
    s_valid = bus.o_valid;
    s_ready = bus.o_ready;
    s_mag   = bus.o_magnitude;
    s_edge  = bus.o_edge;
    if (held_valid) begin
      check("hold_valid", {31'd0, s_valid}, 32'd1);
      check("hold_mag", {24'd0, s_mag}, {24'd0, held_mag});
      check("hold_edge", {31'd0, s_edge}, {31'd0, held_edge});
    end
    if (s_valid && bus.i_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", {31'd0, s_valid}, 32'd0);
      end else begin
        r = exp_q.pop_front();
        check("mag", {24'd0, s_mag}, {24'd0, r.mag});
        check("edge", {31'd0, s_edge}, {31'd0, r.edg});
        delivered++;
      end
    end
    held_valid = s_valid && !bus.i_ready;
    held_mag   = s_mag;
    held_edge  = s_edge;
    accepted   = bus.i_valid && bus.o_ready;
    if (accepted) exp_q.push_back({vecs[cur_idx].mag, vecs[cur_idx].edg});
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input int idx);
    drive(idx);
    cycle();
    check("accept", {31'd0, accepted}, 32'd1);
    idle();
    repeat (3) cycle();
  endtask

  // Directed sequence.
  initial begin
    n_checks = 0; n_fails = 0; delivered = 0; cur_idx = 0;
    accepted = 1'b0; held_valid = 1'b0; held_mag = '0; held_edge = 1'b0;
    s_valid = 1'b0; s_ready = 1'b0; s_mag = '0; s_edge = 1'b0;

    //               tl     t      tr     ml     mr     bl     b      br       thr    mag    edge
    vecs[0] = '{mat(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80), 8'h40, 8'h00, 1'b0};
    vecs[1] = '{mat(8'h00, 8'h80, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h80, 8'hFF), 8'h40, 8'hFF, 1'b1};
    vecs[2] = '{mat(8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00), 8'h40, 8'hFF, 1'b1};
    vecs[3] = '{mat(8'h00, 8'h00, 8'h10, 8'h00, 8'h10, 8'h00, 8'h00, 8'h10), 8'h40, 8'h40, 1'b1};
    vecs[4] = '{mat(8'h00, 8'h00, 8'h10, 8'h00, 8'h10, 8'h00, 8'h00, 8'h10), 8'h41, 8'h40, 1'b0};
    // Gx=34, Gy=-104 -> 138, just under threshold 139.
    vecs[5] = '{mat(8'h10, 8'h20, 8'h30, 8'h00, 8'h00, 8'h05, 8'h06, 8'h07), 8'h8B, 8'h8A, 1'b0};
    // Gy=-128, magnitude equal to threshold.
    vecs[6] = '{mat(8'h20, 8'h20, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8'h80, 8'h80, 1'b1};
    // Gy=256: first raw value that clamps.
    vecs[7] = '{mat(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h40, 8'h40), 8'hFF, 8'hFF, 1'b1};
    stream_idx = '{4, 5, 1, 6, 0};

    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_pixel_matrix = '0;
    bus.i_threshold = '0;

    #12;
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_ready", {31'd0, bus.o_ready}, 32'd1);
    check("rst_mag", {24'd0, bus.o_magnitude}, 32'd0);
    check("rst_edge", {31'd0, bus.o_edge}, 32'd0);

    // Release, then accept on the very first rising edge; latency is 3.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0);
    cycle();
    check("first_accept", {31'd0, accepted}, 32'd1);
    idle();
    for (int k = 1; k <= 3; k++) begin
      cycle();
      check($sformatf("latency_%0d", k), {31'd0, s_valid}, (k == 3) ? 32'd1 : 32'd0);
    end

    run_single(1);
    run_single(2);
    run_single(3);
    run_single(4);
    run_single(5);

    // Data presented without valid must not disturb the held output.
    bus.i_pixel_matrix = mat(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    bus.i_threshold = 8'h00;
    repeat (4) cycle();
    check("bubble_valid", {31'd0, s_valid}, 32'd0);
    check("bubble_mag", {24'd0, s_mag}, 32'h8A);
    check("bubble_edge", {31'd0, s_edge}, 32'd0);

    run_single(6);
    run_single(7);

    // Back-to-back stream with downstream stalled on cycles 4-6.
    begin
      int sent;
      int d0;
      sent = 0;
      d0 = delivered;
      for (int c = 1; c <= 40; c++) begin
        bus.i_ready = !(c >= 4 && c <= 6);
        if (sent < 5) drive(stream_idx[sent]);
        else idle();
        cycle();
        if (accepted) sent++;
        if (c >= 4 && c <= 6) check("stall_ready", {31'd0, s_ready}, 32'd0);
        if (sent == 5 && exp_q.size() == 0) break;
      end
      bus.i_ready = 1'b1;
      check("stream_sent", sent, 5);
      check("stream_count", delivered - d0, 5);
      check("stream_empty", exp_q.size(), 0);
    end

    // Two matrices in flight, one of them already presented, then an async reset.
    bus.i_ready = 1'b0;
    drive(1);
    cycle();
    drive(2);
    cycle();
    idle();
    cycle();
    check("pre_rst_valid", {31'd0, bus.o_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("mid_rst_mag", {24'd0, bus.o_magnitude}, 32'd0);
    check("mid_rst_edge", {31'd0, bus.o_edge}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.o_ready}, 32'd1);
    exp_q.delete();
    held_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    drive(3);
    @(posedge clk);
    #1;
    idle();
    exp_q.push_back({vecs[3].mag, vecs[3].edg});
    for (int k = 1; k <= 3; k++) begin
      cycle();
      check($sformatf("post_rst_lat_%0d", k), {31'd0, s_valid}, (k == 3) ? 32'd1 : 32'd0);
    end
    repeat (6) cycle();
    check("post_rst_valid", {31'd0, s_valid}, 32'd0);
    check("post_rst_ready", {31'd0, s_ready}, 32'd1);
    check("final_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
